// File: rtl/control_unit.sv
// control_unit: multi-cycle FETCH/DECODE/EXECUTE/MEM/WRITEBACK sequencer for a 16-bit core.
// Optional feature macro CU_BRANCH_EN enables JZ (0x9) / JMP (0xA); without it both act as NOPs.
module control_unit (
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] mem_addr,
  input  logic [15:0] mem_rdata,
  output logic [15:0] mem_wdata,
  output logic        mem_rd,
  output logic        mem_wr,
  input  logic        mem_ready,
  output logic [3:0]  rf_ra1,
  output logic [3:0]  rf_ra2,
  input  logic [15:0] rf_rd1,
  input  logic [15:0] rf_rd2,
  output logic [3:0]  rf_wa,
  output logic [15:0] rf_wd,
  output logic        rf_we,
  output logic [15:0] alu_num1,
  output logic [15:0] alu_num2,
  output logic [3:0]  alu_opcode,
  input  logic [15:0] alu_result,
  input  logic        alu_zero,
  output logic        halted
);

  typedef enum logic [2:0] {
    ST_FETCH     = 3'd0,
    ST_DECODE    = 3'd1,
    ST_EXECUTE   = 3'd2,
    ST_MEM       = 3'd3,
    ST_WRITEBACK = 3'd4,
    ST_HALT      = 3'd5
  } state_t;

  localparam logic [3:0] OP_LOAD  = 4'h7;
  localparam logic [3:0] OP_STORE = 4'h8;
  localparam logic [3:0] OP_JZ    = 4'h9;
  localparam logic [3:0] OP_JMP   = 4'hA;
  localparam logic [3:0] OP_HALT  = 4'hF;

  state_t      state_r;
  state_t      state_s;
  logic [15:0] pc_r;
  logic [15:0] ir_r;
  logic [15:0] a_r;
  logic [15:0] b_r;
  logic [15:0] r_r;
  logic        z_r;

  logic [3:0]  op_s;
  logic [3:0]  rd_s;
  logic [3:0]  ra_s;
  logic [3:0]  rb_s;
  logic        alu_op_s;
  logic        branch_s;
  logic        mem_rd_s;
  logic        mem_wr_s;
  logic        rf_we_s;

  assign op_s     = ir_r[15:12];
  assign rd_s     = ir_r[11:8];
  assign ra_s     = ir_r[7:4];
  assign rb_s     = ir_r[3:0];
  assign alu_op_s = (op_s >= 4'h1) && (op_s <= 4'h6);

`ifdef CU_BRANCH_EN
  assign branch_s = (state_r == ST_EXECUTE) &&
                    ((op_s == OP_JMP) || ((op_s == OP_JZ) && z_r));
`else
  // Z is still tracked so both builds share one datapath; nothing consumes it here.
  logic unused_z_s;
  assign branch_s   = 1'b0;
  assign unused_z_s = z_r;
`endif

  // Strobes are gated by rst so an in-flight access is dropped during the reset cycle.
  assign mem_rd = mem_rd_s & ~rst;
  assign mem_wr = mem_wr_s & ~rst;
  assign rf_we  = rf_we_s & ~rst;
  assign halted = (state_r == ST_HALT);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_FETCH;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state and output decode
  always_comb begin
    state_s    = state_r;
    mem_addr   = 16'h0000;
    mem_wdata  = 16'h0000;
    mem_rd_s   = 1'b0;
    mem_wr_s   = 1'b0;
    rf_ra1     = 4'h0;
    rf_ra2     = 4'h0;
    rf_wa      = 4'h0;
    rf_wd      = 16'h0000;
    rf_we_s    = 1'b0;
    alu_num1   = 16'h0000;
    alu_num2   = 16'h0000;
    alu_opcode = 4'h0;
    case (state_r)
      ST_FETCH: begin
        mem_rd_s = 1'b1;
        mem_addr = pc_r;
        if (mem_ready) begin
          state_s = ST_DECODE;
        end else begin
          state_s = ST_FETCH;
        end
      end
      ST_DECODE: begin
        rf_ra1 = ra_s;
        // STORE reads its data register through the second port
        if (op_s == OP_STORE) begin
          rf_ra2 = rd_s;
        end else begin
          rf_ra2 = rb_s;
        end
        state_s = ST_EXECUTE;
      end
      ST_EXECUTE: begin
        case (op_s)
          4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6: begin
            alu_num1   = a_r;
            alu_num2   = b_r;
            alu_opcode = op_s;
            state_s    = ST_WRITEBACK;
          end
          OP_LOAD, OP_STORE: state_s = ST_MEM;
          OP_HALT:           state_s = ST_HALT;
          default:           state_s = ST_FETCH;
        endcase
      end
      ST_MEM: begin
        mem_addr = a_r;
        if (op_s == OP_STORE) begin
          mem_wr_s  = 1'b1;
          mem_wdata = b_r;
        end else begin
          mem_rd_s = 1'b1;
        end
        if (!mem_ready) begin
          state_s = ST_MEM;
        end else if (op_s == OP_STORE) begin
          state_s = ST_FETCH;
        end else begin
          state_s = ST_WRITEBACK;
        end
      end
      ST_WRITEBACK: begin
        rf_we_s = 1'b1;
        rf_wa   = rd_s;
        rf_wd   = r_r;
        state_s = ST_FETCH;
      end
      ST_HALT: state_s = ST_HALT;
      default: state_s = ST_FETCH;
    endcase
  end

  // Datapath registers: PC, IR, operands, result and zero flag
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_r <= 16'h0000;
      ir_r <= 16'h0000;
      a_r  <= 16'h0000;
      b_r  <= 16'h0000;
      r_r  <= 16'h0000;
      z_r  <= 1'b0;
    end else begin
      case (state_r)
        ST_FETCH: begin
          if (mem_ready) begin
            ir_r <= mem_rdata;
            pc_r <= pc_r + 16'd1;
          end
        end
        ST_DECODE: begin
          a_r <= rf_rd1;
          b_r <= rf_rd2;
        end
        ST_EXECUTE: begin
          if (alu_op_s) begin
            r_r <= alu_result;
            z_r <= alu_zero;
          end
          if (branch_s) begin
            pc_r <= a_r;
          end
        end
        ST_MEM: begin
          if (mem_ready && (op_s == OP_LOAD)) begin
            r_r <= mem_rdata;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
